simt_reconv_pc: RTL and testbench

// - Per-block program counter with a parametrised SIMT reconvergence stack.
// - Replaces the single-level SSY/SYNC mask logic with nested divergence up to STACK_DEPTH levels.
// - Sits between the decoder and the fetcher in each core; drives current_pc to fetch and thread_mask to the ALU/LSU/regfile lanes.

---
 rtl/simt_pc_pkg.sv | 23 ++
 rtl/reconv_stack.sv | 77 +++++++
 rtl/simt_reconv_pc.sv | 139 +++++++++++++
 tb/tb_simt_reconv_pc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_pc_pkg.sv
// Shared constants, phase encoding and lane helper for the SIMT reconvergence PC.
package simt_pc_pkg;

   localparam logic [2:0] CORE_EXECUTE = 3'b101;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   localparam int unsigned MAX_LANES   = 32;
   localparam int unsigned LANE_IDX_W  = 5;

   typedef enum logic {
      PH_THEN = 1'b0,
      PH_ELSE = 1'b1
   } phase_e;

   // Lowest set lane index; returns 0 for an empty mask.
   function automatic logic [LANE_IDX_W-1:0] first_active(input logic [MAX_LANES-1:0] mask);
      first_active = '0;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if (mask[i]) first_active = LANE_IDX_W'(i);
      end
   endfunction

endpackage

// File: rtl/reconv_stack.sv
// LIFO of reconvergence entries: push new region, pop finished region, flip top to else-path.
module reconv_stack
   import simt_pc_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned PC_W  = 8,
   parameter  int unsigned LANES = 4,
   localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              wr_top_i,
   input  logic [PC_W-1:0]   push_alt_pc_i,
   input  logic [LANES-1:0]  push_alt_mask_i,
   input  logic [LANES-1:0]  push_outer_mask_i,
   input  logic [PC_W-1:0]   wr_resume_pc_i,
   output logic [PC_W-1:0]   top_alt_pc_o,
   output logic [LANES-1:0]  top_alt_mask_o,
   output logic [LANES-1:0]  top_outer_mask_o,
   output logic [PC_W-1:0]   top_resume_pc_o,
   output phase_e            top_phase_o,
   output logic              full_c_o,
   output logic              empty_c_o,
   output logic [LVL_W-1:0]  level_o
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PC_W-1:0]  alt_pc_q     [DEPTH];
   logic [LANES-1:0] alt_mask_q   [DEPTH];
   logic [LANES-1:0] outer_mask_q [DEPTH];
   logic [PC_W-1:0]  resume_pc_q  [DEPTH];
   phase_e           phase_q      [DEPTH];
   logic [LVL_W-1:0] level_q;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] top_idx;

   assign push_idx = IDX_W'(level_q);
   assign top_idx  = IDX_W'(level_q - LVL_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            alt_pc_q[i]     <= '0;
            alt_mask_q[i]   <= '0;
            outer_mask_q[i] <= '0;
            resume_pc_q[i]  <= '0;
            phase_q[i]      <= PH_THEN;
         end
      end else if (push_i) begin
         alt_pc_q[push_idx]     <= push_alt_pc_i;
         alt_mask_q[push_idx]   <= push_alt_mask_i;
         outer_mask_q[push_idx] <= push_outer_mask_i;
         resume_pc_q[push_idx]  <= '0;
         phase_q[push_idx]      <= PH_THEN;
         level_q                <= level_q + LVL_W'(1);
      end else if (pop_i) begin
         level_q <= level_q - LVL_W'(1);
      end else if (wr_top_i) begin
         resume_pc_q[top_idx] <= wr_resume_pc_i;
         phase_q[top_idx]     <= PH_ELSE;
      end
   end

   assign top_alt_pc_o     = alt_pc_q[top_idx];
   assign top_alt_mask_o   = alt_mask_q[top_idx];
   assign top_outer_mask_o = outer_mask_q[top_idx];
   assign top_resume_pc_o  = resume_pc_q[top_idx];
   assign top_phase_o      = phase_q[top_idx];
   assign full_c_o         = (level_q == LVL_W'(DEPTH));
   assign empty_c_o        = (level_q == '0);
   assign level_o          = level_q;

endmodule

// File: rtl/simt_reconv_pc.sv
// Per-block PC with nested SSY/SYNC divergence; drives fetch PC and the active-lane mask.
module simt_reconv_pc
   import simt_pc_pkg::*;
#(
   parameter  int unsigned PROGRAM_MEM_ADDR_BITS = 8,
   parameter  int unsigned DATA_MEM_DATA_BITS    = 8,
   parameter  int unsigned THREADS_PER_BLOCK     = 4,
   parameter  int unsigned STACK_DEPTH           = 4,
   localparam int unsigned PCW                   = PROGRAM_MEM_ADDR_BITS,
   localparam int unsigned TPB                   = THREADS_PER_BLOCK,
   localparam int unsigned LVL_W                 = $clog2(STACK_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [2:0]                    core_state,
   input  logic                          decoded_pc_mux,
   input  logic                          decoded_ssy,
   input  logic                          decoded_sync,
   input  logic [2:0]                    decoded_nzp,
   input  logic [DATA_MEM_DATA_BITS-1:0] decoded_immediate,
   input  logic [3*TPB-1:0]              nzp,
   output logic [TPB-1:0]                thread_mask,
   output logic [PCW-1:0]                current_pc,
   output logic [PCW-1:0]                next_pc,
   output logic [LVL_W-1:0]              stack_level,
   output logic                          stack_err
);

   logic [PCW-1:0]        current_pc_q, current_pc_d;
   logic [PCW-1:0]        next_pc_q, next_pc_d;
   logic [TPB-1:0]        mask_q, mask_d;
   logic                  err_q, err_d;
   logic [PCW-1:0]        pc_inc;
   logic [PCW-1:0]        imm_pc;
   logic [TPB-1:0]        match;
   logic [LANE_IDX_W-1:0] ref_idx;
   logic                  br_taken;
   logic                  push_c, pop_c, wr_top_c;
   logic [PCW-1:0]        top_alt_pc, top_resume_pc;
   logic [TPB-1:0]        top_alt_mask, top_outer_mask;
   phase_e                top_phase;
   logic                  full_c, empty_c;

   assign pc_inc = current_pc_q + PCW'(1);
   assign imm_pc = PCW'(decoded_immediate);

   // Per-lane condition match against the decoded NZP mask.
   always_comb begin
      match = '0;
      for (int i = 0; i < TPB; i++) begin
         match[i] = |(nzp[3*i +: 3] & decoded_nzp);
      end
   end

   assign ref_idx  = first_active(MAX_LANES'(mask_q));
   assign br_taken = (|mask_q) && (|(match & (TPB'(1) << ref_idx)));

   reconv_stack #(
      .DEPTH (STACK_DEPTH),
      .PC_W  (PCW),
      .LANES (TPB)
   ) u_stack (
      .clk               (clk),
      .reset             (reset),
      .push_i            (push_c),
      .pop_i             (pop_c),
      .wr_top_i          (wr_top_c),
      .push_alt_pc_i     (imm_pc),
      .push_alt_mask_i   (mask_q & ~match),
      .push_outer_mask_i (mask_q),
      .wr_resume_pc_i    (pc_inc),
      .top_alt_pc_o      (top_alt_pc),
      .top_alt_mask_o    (top_alt_mask),
      .top_outer_mask_o  (top_outer_mask),
      .top_resume_pc_o   (top_resume_pc),
      .top_phase_o       (top_phase),
      .full_c_o          (full_c),
      .empty_c_o         (empty_c),
      .level_o           (stack_level)
   );

   // Decode priority pc_mux > sync > ssy, evaluated only in EXECUTE.
   always_comb begin
      next_pc_d = next_pc_q;
      mask_d    = mask_q;
      err_d     = err_q;
      push_c    = 1'b0;
      pop_c     = 1'b0;
      wr_top_c  = 1'b0;
      if (core_state == CORE_EXECUTE) begin
         next_pc_d = pc_inc;
         if (decoded_pc_mux) begin
            if (br_taken) next_pc_d = imm_pc;
         end else if (decoded_sync) begin
            if (empty_c) begin
               err_d  = 1'b1;
               mask_d = '1;
            end else if (top_phase == PH_THEN) begin
               wr_top_c  = 1'b1;
               mask_d    = top_alt_mask;
               next_pc_d = top_alt_pc;
            end else begin
               pop_c     = 1'b1;
               mask_d    = top_outer_mask;
               next_pc_d = top_resume_pc;
            end
         end else if (decoded_ssy) begin
            if (full_c) begin
               err_d = 1'b1;
            end else begin
               push_c = 1'b1;
               mask_d = mask_q & match;
            end
         end
      end
   end

   assign current_pc_d = (core_state == CORE_UPDATE) ? next_pc_q : current_pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         current_pc_q <= '0;
         next_pc_q    <= '0;
         mask_q       <= '1;
         err_q        <= 1'b0;
      end else begin
         current_pc_q <= current_pc_d;
         next_pc_q    <= next_pc_d;
         mask_q       <= mask_d;
         err_q        <= err_d;
      end
   end

   assign current_pc  = current_pc_q;
   assign next_pc     = next_pc_q;
   assign thread_mask = mask_q;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_simt_reconv_pc.sv
// Bench for simt_reconv_pc: directed scenarios plus randomized traffic against a queue-based model.
module tb_simt_reconv_pc;

   localparam int PCW = 8;
   localparam int DW  = 8;
   localparam int TPB = 4;
   localparam int SD  = 2;
   localparam int LW  = $clog2(SD + 1);

   localparam logic [2:0]  ST_EX   = 3'b101;
   localparam logic [2:0]  ST_UP   = 3'b110;
   localparam logic [2:0]  ST_IDLE = 3'b000;
   localparam logic [11:0] LN_NPZP = 12'b001_010_001_100;
   localparam logic [11:0] LN_ALLP = 12'b001_001_001_001;

   logic           clk = 1'b0;
   logic           reset;
   logic [2:0]     core_state;
   logic           decoded_pc_mux, decoded_ssy, decoded_sync;
   logic [2:0]     decoded_nzp;
   logic [DW-1:0]  decoded_immediate;
   logic [3*TPB-1:0] nzp;
   logic [TPB-1:0] thread_mask;
   logic [PCW-1:0] current_pc, next_pc;
   logic [LW-1:0]  stack_level;
   logic           stack_err;

   always #5 clk = ~clk;

   simt_reconv_pc #(
      .PROGRAM_MEM_ADDR_BITS (PCW),
      .DATA_MEM_DATA_BITS    (DW),
      .THREADS_PER_BLOCK     (TPB),
      .STACK_DEPTH           (SD)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .core_state        (core_state),
      .decoded_pc_mux    (decoded_pc_mux),
      .decoded_ssy       (decoded_ssy),
      .decoded_sync      (decoded_sync),
      .decoded_nzp       (decoded_nzp),
      .decoded_immediate (decoded_immediate),
      .nzp               (nzp),
      .thread_mask       (thread_mask),
      .current_pc        (current_pc),
      .next_pc           (next_pc),
      .stack_level       (stack_level),
      .stack_err         (stack_err)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: divergence regions held as a queue of records.
   typedef struct {
      logic [PCW-1:0] alt_pc;
      logic [TPB-1:0] alt_mask;
      logic [TPB-1:0] outer_mask;
      logic [PCW-1:0] resume_pc;
      bit             else_running;
   } region_t;

   region_t        stk[$];
   logic [PCW-1:0] m_pc, m_next;
   logic [TPB-1:0] m_mask;
   bit             m_err;
   bit             model_valid = 1'b0;

   task automatic model_step();
      logic [PCW-1:0] inc, npc;
      logic [TPB-1:0] nmask, t_lanes;
      region_t        r;
      inc   = m_pc + 8'd1;
      npc   = inc;
      nmask = m_mask;
      t_lanes = '0;
      for (int i = 0; i < TPB; i++)
         t_lanes[i] = m_mask[i] && ((nzp[3*i +: 3] & decoded_nzp) != 3'b000);
      if (reset) begin
         m_pc = '0; m_next = '0; m_mask = '1; m_err = 1'b0;
         stk.delete();
         model_valid = 1'b1;
      end else if (core_state == ST_EX) begin
         if (decoded_pc_mux) begin
            for (int i = 0; i < TPB; i++) begin
               if (m_mask[i]) begin
                  if ((nzp[3*i +: 3] & decoded_nzp) != 3'b000) npc = decoded_immediate;
                  break;
               end
            end
         end else if (decoded_sync) begin
            if (stk.size() == 0) begin
               m_err = 1'b1;
               nmask = '1;
            end else begin
               r = stk[stk.size() - 1];
               if (!r.else_running) begin
                  r.resume_pc    = inc;
                  r.else_running = 1'b1;
                  stk[stk.size() - 1] = r;
                  nmask = r.alt_mask;
                  npc   = r.alt_pc;
               end else begin
                  void'(stk.pop_back());
                  nmask = r.outer_mask;
                  npc   = r.resume_pc;
               end
            end
         end else if (decoded_ssy) begin
            if (stk.size() == SD) begin
               m_err = 1'b1;
            end else begin
               r.alt_pc       = decoded_immediate;
               r.alt_mask     = m_mask & ~t_lanes;
               r.outer_mask   = m_mask;
               r.resume_pc    = '0;
               r.else_running = 1'b0;
               stk.push_back(r);
               nmask = t_lanes;
            end
         end
         m_next = npc;
         m_mask = nmask;
      end else if (core_state == ST_UP) begin
         m_pc = m_next;
      end
   endtask

   // Advance the model at each edge, then compare all outputs just after it.
   always @(posedge clk) begin
      model_step();
      #1;
      if (model_valid) begin
         chk("cyc_current_pc", 32'(current_pc), 32'(m_pc));
         chk("cyc_next_pc", 32'(next_pc), 32'(m_next));
         chk("cyc_thread_mask", 32'(thread_mask), 32'(m_mask));
         chk("cyc_stack_level", 32'(stack_level), 32'(stk.size()));
         chk("cyc_stack_err", 32'(stack_err), 32'(m_err));
      end
   end

   task automatic cyc(input logic [2:0] st, input logic pm, input logic sy, input logic sn,
                      input logic [2:0] dn, input logic [7:0] imm, input logic [11:0] ln);
      core_state        = st;
      decoded_pc_mux    = pm;
      decoded_ssy       = sy;
      decoded_sync      = sn;
      decoded_nzp       = dn;
      decoded_immediate = imm;
      nzp               = ln;
      @(posedge clk);
      #2;
   endtask

   task automatic ex(input logic pm, input logic sy, input logic sn,
                     input logic [2:0] dn, input logic [7:0] imm, input logic [11:0] ln);
      cyc(ST_EX, pm, sy, sn, dn, imm, ln);
   endtask

   task automatic up();
      cyc(ST_UP, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0, 12'd0);
   endtask

   task automatic plain(input int n);
      for (int k = 0; k < n; k++) begin
         ex(1'b0, 1'b0, 1'b0, 3'b000, 8'd0, 12'd0);
         up();
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int k = 0; k < n; k++) cyc(ST_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0, 12'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      do_reset(2);
      chk("rst_pc", 32'(current_pc), 32'd0);
      chk("rst_next", 32'(next_pc), 32'd0);
      chk("rst_mask", 32'(thread_mask), 32'hF);
      chk("rst_level", 32'(stack_level), 32'd0);
      chk("rst_err", 32'(stack_err), 32'd0);

      plain(3);
      chk("linear_pc3", 32'(current_pc), 32'd3);
      plain(2);

      ex(1'b0, 1'b1, 1'b0, 3'b001, 8'd20, LN_NPZP);
      chk("ssy_mask", 32'(thread_mask), 32'hA);
      chk("ssy_next", 32'(next_pc), 32'd6);
      chk("ssy_level", 32'(stack_level), 32'd1);
      chk("mdl_ssy_mask", 32'(m_mask), 32'hA);
      up();
      plain(3);
      chk("then_pc9", 32'(current_pc), 32'd9);
      ex(1'b0, 1'b0, 1'b1, 3'b000, 8'd0, 12'd0);
      chk("sync1_mask", 32'(thread_mask), 32'h5);
      chk("sync1_next", 32'(next_pc), 32'd20);
      chk("mdl_sync1_next", 32'(m_next), 32'd20);
      up();
      plain(4);
      ex(1'b0, 1'b0, 1'b1, 3'b000, 8'd0, 12'd0);
      chk("sync2_mask", 32'(thread_mask), 32'hF);
      chk("sync2_next", 32'(next_pc), 32'd10);
      chk("sync2_level", 32'(stack_level), 32'd0);
      chk("mdl_sync2_next", 32'(m_next), 32'd10);
      up();

      do_reset(1);
      plain(7);
      ex(1'b0, 1'b0, 1'b1, 3'b000, 8'd0, 12'd0);
      chk("under_err", 32'(stack_err), 32'd1);
      chk("under_next", 32'(next_pc), 32'd8);
      chk("under_mask", 32'(thread_mask), 32'hF);
      chk("under_level", 32'(stack_level), 32'd0);
      up();
      ex(1'b0, 1'b1, 1'b0, 3'b001, 8'h33, LN_NPZP);
      up();
      ex(1'b1, 1'b0, 1'b0, 3'b001, 8'd40, LN_NPZP);
      chk("br_taken_next", 32'(next_pc), 32'd40);
      chk("mdl_br_taken", 32'(m_next), 32'd40);
      ex(1'b1, 1'b0, 1'b0, 3'b100, 8'd40, LN_NPZP);
      chk("br_reflane_not_taken", 32'(next_pc), 32'd10);
      chk("br_keeps_mask", 32'(thread_mask), 32'hA);

      do_reset(1);
      for (int k = 0; k < 2; k++) begin
         ex(1'b0, 1'b1, 1'b0, 3'b001, 8'h50, LN_ALLP);
         up();
      end
      chk("ovf_level2", 32'(stack_level), 32'd2);
      chk("ovf_err_pre", 32'(stack_err), 32'd0);
      ex(1'b0, 1'b1, 1'b0, 3'b001, 8'h50, LN_ALLP);
      chk("ovf_level", 32'(stack_level), 32'd2);
      chk("ovf_err", 32'(stack_err), 32'd1);
      chk("ovf_mask", 32'(thread_mask), 32'hF);
      up();

      do_reset(1);
      chk("midrst_mask", 32'(thread_mask), 32'hF);
      chk("midrst_level", 32'(stack_level), 32'd0);
      chk("midrst_pc", 32'(current_pc), 32'd0);
      chk("midrst_err", 32'(stack_err), 32'd0);

      for (int k = 0; k < 3000; k++) begin
         logic [2:0] st;
         int unsigned r;
         r = $urandom_range(0, 7);
         if (r < 4)      st = ST_EX;
         else if (r < 7) st = ST_UP;
         else            st = 3'($urandom);
         reset = ($urandom_range(0, 149) == 0);
         cyc(st, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom), 12'($urandom));
      end
      reset = 1'b0;
      cyc(ST_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0, 12'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
